// File: rtl/uart_defines_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// transmit FSM states, register offsets and STATUS bit positions.
package uart_defines;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [31:0] OFS_TXDATA = 32'd0;
    localparam logic [31:0] OFS_STATUS = 32'd4;

    localparam int unsigned STAT_FULL     = 0;
    localparam int unsigned STAT_EMPTY    = 1;
    localparam int unsigned STAT_BUSY     = 2;
    localparam int unsigned STAT_OVERFLOW = 3;
    localparam int unsigned STAT_PARITY   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy count one bit wider than the
// pointers. Pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter snooping the store bus.
// TXDATA at BASE_ADDR queues a byte; STATUS at BASE_ADDR+4 reads
// {parity_en, overflow, busy, empty, full}; a store to STATUS clears overflow.
// Optional even parity bit after the data bits: define UART_TX_PARITY_EN.
module mmio_uart_tx
    import uart_defines::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        read_hit,
    output logic        tx
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t   state, state_nxt;
    logic [CW-1:0] baud_cnt, baud_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        baud_done;
    logic        txdata_wr;
    logic        status_wr;
    logic        overflow;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [31:0] status;
    logic [23:0] unused_wdata;

    assign unused_wdata = write_data[31:8];
    assign txdata_wr    = write_enable && (write_address == BASE_ADDR + OFS_TXDATA);
    assign status_wr    = write_enable && (write_address == BASE_ADDR + OFS_STATUS);
    assign baud_done    = (baud_cnt == BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (txdata_wr),
        .pop   (fifo_pop),
        .din   (write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    // Even parity of the byte, captured when it leaves the FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_bit <= 1'b0;
        end else if (fifo_pop) begin
            parity_bit <= ^fifo_dout;
        end
    end
`endif

    // Sticky overflow: set by a dropped TXDATA store, cleared by a STATUS store
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (txdata_wr && fifo_full) begin
            overflow <= 1'b1;
        end else if (status_wr) begin
            overflow <= 1'b0;
        end
    end

    // Transmit FSM state, baud counter, bit index and shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
        end
    end

    // Next-state, counter reload and serial output per state
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + 1'b1;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        fifo_pop  = 1'b0;
        tx        = 1'b1;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_dout;
                    state_nxt = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_done) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx = shift[0];
                if (baud_done) begin
                    baud_nxt  = '0;
                    shift_nxt = shift >> 1;
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = parity_bit;
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                baud_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // STATUS word assembly and read-port mux
    always_comb begin
        status                = '0;
        status[STAT_FULL]     = fifo_full;
        status[STAT_EMPTY]    = fifo_empty;
        status[STAT_BUSY]     = (state != IDLE);
        status[STAT_OVERFLOW] = overflow;
`ifdef UART_TX_PARITY_EN
        status[STAT_PARITY]   = 1'b1;
`endif
        read_hit  = (read_address == BASE_ADDR + OFS_STATUS);
        read_data = read_hit ? status : '0;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;

`ifdef UART_TX_PARITY_EN
    localparam int          FBITS = 11;
    localparam logic [31:0] PBIT  = 32'h10;
    // frame bit i is sent i-th: start, d0..d7, parity, stop
    localparam logic [10:0] F55 = 11'b10010101010;
    localparam logic [10:0] FA0 = 11'b10101000000;
    localparam logic [10:0] F0F = 11'b10000011110;
`else
    localparam int          FBITS = 10;
    localparam logic [31:0] PBIT  = 32'h0;
    // frame bit i is sent i-th: start, d0..d7, stop
    localparam logic [10:0] F55 = 11'b1010101010;
    localparam logic [10:0] FA0 = 11'b1101000000;
    localparam logic [10:0] F0F = 11'b1000011110;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_address;
    logic [31:0] read_data;
    logic        read_hit;
    logic        tx;

    int vectors     = 0;
    int miscompares = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .read_address  (read_address),
        .read_data     (read_data),
        .read_hit      (read_hit),
        .tx            (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte queue plus the per-cycle tx waveform still to be sent
    logic [7:0] mq[$];
    bit         mwave[$];
    bit         movf;
    bit         m_idle;
    int         m_n;
    logic [7:0] m_b;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mwave.delete();
            movf = 1'b0;
        end else begin
            m_idle = (mwave.size() == 0);
            m_n    = mq.size();
            if (!m_idle) void'(mwave.pop_front());
            if (m_idle && m_n > 0) begin
                m_b = mq.pop_front();
                for (int c = 0; c < CPB; c++) mwave.push_back(1'b0);
                for (int i = 0; i < 8; i++)
                    for (int c = 0; c < CPB; c++) mwave.push_back(m_b[i]);
`ifdef UART_TX_PARITY_EN
                for (int c = 0; c < CPB; c++) mwave.push_back(^m_b);
`endif
                for (int c = 0; c < CPB; c++) mwave.push_back(1'b1);
            end
            if (write_enable && write_address == BASE) begin
                if (m_n < DEPTH) mq.push_back(write_data[7:0]);
                else movf = 1'b1;
            end else if (write_enable && write_address == BASE + 32'd4) begin
                movf = 1'b0;
            end
        end
    end

    function automatic logic [31:0] m_status();
        return PBIT | {28'b0, movf, (mwave.size() != 0), (mq.size() == 0), (mq.size() == DEPTH)};
    endfunction

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            check("tx", {31'b0, tx}, {31'b0, (mwave.size() != 0) ? mwave[0] : 1'b1});
            check("read_hit", {31'b0, read_hit}, {31'b0, read_address == BASE + 32'd4});
            check("read_data", read_data, (read_address == BASE + 32'd4) ? m_status() : 32'h0);
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        write_address = a;
        write_data    = d;
        write_enable  = 1'b1;
        @(posedge clk);
        #1;
        write_enable  = 1'b0;
        write_address = 32'h0;
        write_data    = 32'h0;
    endtask

    task automatic check_frame(input logic [10:0] f, input string nm);
        for (int i = 0; i < FBITS; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                check(nm, {31'b0, tx}, {31'b0, f[i]});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        write_enable  = 1'b0;
        write_address = 32'h0;
        write_data    = 32'h0;
        read_address  = BASE + 32'd4;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'b0, tx}, 32'h1);
        check("reset_status", read_data, 32'h2 | PBIT);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // single byte 0x55: one idle cycle, then the frame, then STATUS empty
        store(BASE, 32'hFFFF_FF55);
        @(negedge clk);
        check("t1_idle", {31'b0, tx}, 32'h1);
        check_frame(F55, "t1_frame");
        @(negedge clk);
        check("t1_after_tx", {31'b0, tx}, 32'h1);
        check("t1_status", read_data, 32'h2 | PBIT);
        @(posedge clk);
        #1;

        // STATUS right after the pop, with a stray store on the pop edge
        store(BASE, 32'h0000_00C3);
        store(BASE + 32'd8, 32'h0000_0077);
        @(negedge clk);
        check("t2_hit", {31'b0, read_hit}, 32'h1);
        check("t2_status_busy", read_data, 32'h6 | PBIT);
        repeat (FBITS * CPB + 4) @(posedge clk);
        #1;
        check("t2_status_done", read_data, 32'h2 | PBIT);

        // overflow: six pushes, first byte in flight, four queued, last dropped
        for (int k = 0; k < 6; k++) store(BASE, 32'h10 + k);
        check("t3_overflow", read_data, 32'hD | PBIT);
        store(BASE + 32'd4, 32'hFFFF_FFFF);
        check("t3_ovf_clear", read_data, 32'h5 | PBIT);
        repeat (5 * (FBITS * CPB + 1) + 4) @(posedge clk);
        #1;
        check("t3_drained", read_data, 32'h2 | PBIT);

        // back-to-back frames with a single idle-high cycle between them
        store(BASE, 32'h0000_00A0);
        store(BASE, 32'h0000_000F);
        check_frame(FA0, "t4_frame_a0");
        @(negedge clk);
        check("t4_gap", {31'b0, tx}, 32'h1);
        check_frame(F0F, "t4_frame_0f");
        @(negedge clk);
        check("t4_end", {31'b0, tx}, 32'h1);
        @(posedge clk);
        #1;

        // reset in the middle of data bit 3 of 0xA5 (bit 3 = 0)
        store(BASE, 32'h0000_00A5);
        repeat (18) @(posedge clk);
        #1;
        check("t5_bit3", {31'b0, tx}, 32'h0);
        rst = 1'b0;
        #1;
        check("t5_rst_tx", {31'b0, tx}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("t5_status", read_data, 32'h2 | PBIT);
        repeat (FBITS * CPB + 4) @(posedge clk);
        #1;
        check("t5_tx_idle", {31'b0, tx}, 32'h1);

`ifdef UART_TX_PARITY_EN
        // parity: 0x07 has odd weight -> parity 1; 0x03 -> parity 0
        store(BASE, 32'h0000_0007);
        @(negedge clk);
        check_frame(11'b11000001110, "t6_frame_07");
        @(posedge clk);
        #1;
        store(BASE, 32'h0000_0003);
        @(negedge clk);
        check_frame(11'b10000000110, "t6_frame_03");
        @(posedge clk);
        #1;
`endif

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
